// File: rtl/fmac2fib_rxctrl_if.sv
// FMAC RX FIFO / FIB read FIFO signal bundle for the receive controller.
// Latency: n/a (wires only).
// Backpressure: n/a; modports: master = controller, slave = FIFO side.
//   FMAC side: fib_mac_rx_empty/data/rd, fib_mac_rx_stat_empty/stat/stat_rd
//   FIB side : wrusedw_rf, wren_rf, datain_rf, wrfull_rcf, wren_rcf, datain_rcf
interface fmac2fib_rxctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int BCNT_WIDTH = 32,
  parameter int RF_AW      = 12
);
  logic                  fib_mac_rx_empty;
  logic [DATA_WIDTH-1:0] fib_mac_rx_data;
  logic                  fib_mac_rx_rd;
  logic                  fib_mac_rx_stat_empty;
  logic [BCNT_WIDTH-1:0] fib_mac_rx_stat;
  logic                  fib_mac_rx_stat_rd;
  logic [RF_AW-1:0]      wrusedw_rf;
  logic                  wren_rf;
  logic [DATA_WIDTH-1:0] datain_rf;
  logic                  wrfull_rcf;
  logic                  wren_rcf;
  logic [BCNT_WIDTH-1:0] datain_rcf;

  modport master (
    input  fib_mac_rx_empty, fib_mac_rx_data, fib_mac_rx_stat_empty, fib_mac_rx_stat,
    input  wrusedw_rf, wrfull_rcf,
    output fib_mac_rx_rd, fib_mac_rx_stat_rd, wren_rf, datain_rf, wren_rcf, datain_rcf
  );

  modport slave (
    output fib_mac_rx_empty, fib_mac_rx_data, fib_mac_rx_stat_empty, fib_mac_rx_stat,
    output wrusedw_rf, wrfull_rcf,
    input  fib_mac_rx_rd, fib_mac_rx_stat_rd, wren_rf, datain_rf, wren_rcf, datain_rcf
  );
endinterface

// File: rtl/fmac2fib_rxctrl.sv
// Moves one FMAC RX frame (status + ceil(bc/8) data words) into rf, then its count into rcf.
// Latency: rf write 1 cycle after each FMAC read; frame-to-frame gap of at least 3 cycles.
// Backpressure: waits in CHECK until rf holds the whole frame; waits in IDLE while rcf is full.
//   Ports: clk_fib, reset (async, active-high), bus (FIFO interface, master),
//          drop_cnt (saturating dropped-frame count), test (high in DATA or DROP).
module fmac2fib_rxctrl #(
  parameter int          DATA_WIDTH = 64,
  parameter int          BCNT_WIDTH = 32,
  parameter int          RF_AW      = 12,
  parameter logic [15:0] MAX_BCNT   = 16'd9600
) (
  input  logic               clk_fib,
  input  logic               reset,
  fmac2fib_rxctrl_if.master  bus,
  output logic [15:0]        drop_cnt,
  output logic               test
);

  typedef enum logic [2:0] {IDLE, STAT, CHECK, DATA, DONE, DROP} state_t;

  localparam logic [31:0] RF_FREE_MAX = 32'((64'd1 << RF_AW) - 64'd1);

  state_t                state_q, state_d;
  logic [15:0]           bc_q;
  logic                  err_q;
  logic [13:0]           rem_q;
  logic                  rd_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [BCNT_WIDTH-1:0] rcf_q;

  logic                  rd_go;
  logic                  frame_end;
  logic                  drop_cond;
  logic                  space_ok;
  logic [16:0]           wcnt;
  logic [31:0]           rf_free;
  logic [BCNT_WIDTH-1:0] rcf_word;
  logic                  stat_rd;
  logic                  wren_rf;
  logic                  wren_rcf;
  logic                  unused_stat_bits;

  // Word count computed at 17 bits so bc=16'hFFFF cannot wrap before the shift.
  assign wcnt      = ({1'b0, bus.fib_mac_rx_stat[15:0]} + 17'd7) >> 3;
  assign rf_free   = RF_FREE_MAX - 32'(bus.wrusedw_rf);
  assign space_ok  = rf_free >= 32'(rem_q);
  assign drop_cond = err_q || (bc_q == 16'd0) || (bc_q > MAX_BCNT);
  assign rcf_word  = BCNT_WIDTH'({bc_q, 16'h0000});
  assign unused_stat_bits = ^bus.fib_mac_rx_stat[BCNT_WIDTH-1:17];

  // DATA and DROP read identically; only the rf write differs.
  assign rd_go     = ((state_q == DATA) || (state_q == DROP)) &&
                     (rem_q != 14'd0) && !bus.fib_mac_rx_empty;
  // The last read's data is still in flight while rd_d is set.
  assign frame_end = (rem_q == 14'd0) && !rd_d;

  always_comb begin
    state_d  = state_q;
    stat_rd  = 1'b0;
    wren_rf  = 1'b0;
    wren_rcf = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.fib_mac_rx_stat_empty && !bus.wrfull_rcf) begin
          stat_rd = 1'b1;
          state_d = STAT;
        end
      end
      STAT:  state_d = CHECK;
      CHECK: begin
        if (drop_cond)     state_d = DROP;
        else if (space_ok) state_d = DATA;
      end
      DATA: begin
        wren_rf = rd_d;
        if (frame_end) state_d = DONE;
      end
      DONE: begin
        wren_rcf = 1'b1;
        state_d  = IDLE;
      end
      DROP: begin
        if (frame_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_fib or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      bc_q     <= 16'd0;
      err_q    <= 1'b0;
      rem_q    <= 14'd0;
      rd_d     <= 1'b0;
      data_q   <= '0;
      rcf_q    <= '0;
      drop_cnt <= 16'd0;
    end else begin
      state_q <= state_d;
      rd_d    <= rd_go;
      if (state_q == STAT) begin
        bc_q  <= bus.fib_mac_rx_stat[15:0];
        err_q <= bus.fib_mac_rx_stat[16];
        rem_q <= wcnt[13:0];
      end else if (rd_go) begin
        rem_q <= rem_q - 14'd1;
      end
      if (wren_rf)
        data_q <= bus.fib_mac_rx_data;
      if (state_q == DONE)
        rcf_q <= rcf_word;
      if ((state_q == DROP) && frame_end && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Write data passes straight through in the write cycle and holds afterwards.
  assign bus.fib_mac_rx_rd      = rd_go;
  assign bus.fib_mac_rx_stat_rd = stat_rd;
  assign bus.wren_rf            = wren_rf;
  assign bus.datain_rf          = wren_rf ? bus.fib_mac_rx_data : data_q;
  assign bus.wren_rcf           = wren_rcf;
  assign bus.datain_rcf         = wren_rcf ? rcf_word : rcf_q;
  assign test                   = (state_q == DATA) || (state_q == DROP);

endmodule

// File: tb/tb_fmac2fib_rxctrl.sv
// Scoreboard bench for fmac2fib_rxctrl: FIFO models feed random frames, a monitor checks rf/rcf writes.
// Latency: checks rf write exactly one cycle after a read.
// Backpressure: exercises rf space stall, rcf full, data bubbles and random FIFO empties.
module tb_fmac2fib_rxctrl;
  localparam int DW = 64;
  localparam int BW = 32;
  localparam int AW = 12;

  logic        clk_fib = 1'b0;
  logic        reset;
  logic [15:0] drop_cnt;
  logic        test;

  always #5 clk_fib = ~clk_fib;

  fmac2fib_rxctrl_if #(.DATA_WIDTH(DW), .BCNT_WIDTH(BW), .RF_AW(AW)) bus();

  fmac2fib_rxctrl #(.DATA_WIDTH(DW), .BCNT_WIDTH(BW), .RF_AW(AW), .MAX_BCNT(16'd9600)) dut (
    .clk_fib (clk_fib),
    .reset   (reset),
    .bus     (bus),
    .drop_cnt(drop_cnt),
    .test    (test)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] dq[$];          // FMAC RX data FIFO contents
  logic [BW-1:0] sq[$];          // FMAC RX status FIFO contents
  logic [DW-1:0] exp_rf[$];      // expected rf words, in order
  logic [BW-1:0] exp_rcf[$];     // expected rcf words
  int            exp_rcf_at[$];  // rf writes that must precede each rcf write
  int            wr_stamps[$];   // cycle of each rf write
  int exp_words_total = 0;
  int exp_drop        = 0;
  int rf_writes       = 0;
  int rd_count        = 0;
  int cyc             = 0;
  int bubble_at       = 0;
  int bubble_left     = 0;
  bit rand_stall      = 1'b0;
  int prev_rd         = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a frame of bc bytes is ceil(bc/8) words; legal frames land in rf/rcf, others count as drops.
  task automatic send_frame(input int bc, input bit err);
    int nw;
    bit good;
    logic [DW-1:0] w;
    logic [15:0] b16;
    nw   = (bc + 7) / 8;
    good = !err && bc >= 1 && bc <= 9600;
    b16  = bc[15:0];
    sq.push_back({15'd0, err, b16});
    for (int i = 0; i < nw; i++) begin
      w = {$urandom(), $urandom()};
      dq.push_back(w);
      if (good) exp_rf.push_back(w);
    end
    if (good) begin
      exp_words_total += nw;
      exp_rcf.push_back({b16, 16'h0000});
      exp_rcf_at.push_back(exp_words_total);
    end else begin
      exp_drop++;
    end
  endtask

  // FMAC FIFO models: data/status valid one cycle after the read strobe.
  task automatic fifo_model();
    forever begin
      @(posedge clk_fib);
      cyc++;
      if (bubble_left > 0) bubble_left--;
      if (bus.fib_mac_rx_rd && dq.size() != 0) begin
        rd_count++;
        bus.fib_mac_rx_data <= dq.pop_front();
        if (bubble_at > 0 && rd_count == bubble_at) bubble_left = 3;
      end
      if (bus.fib_mac_rx_stat_rd && sq.size() != 0)
        bus.fib_mac_rx_stat <= sq.pop_front();
      bus.fib_mac_rx_empty      <= (dq.size() == 0) || (bubble_left > 0) ||
                                   (rand_stall && $urandom_range(3) == 0);
      bus.fib_mac_rx_stat_empty <= (sq.size() == 0);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk_fib);
      if (reset) begin
        prev_rd = 0;
        continue;
      end
      if (bus.fib_mac_rx_rd) check("rd_nonempty", dq.size() != 0, 1);
      if (bus.wren_rf) begin
        check("rf_latency", prev_rd, 1);
        if (exp_rf.size() == 0) check("rf_unexpected", 1, 0);
        else check("rf_data", bus.datain_rf, exp_rf.pop_front());
        rf_writes++;
        wr_stamps.push_back(cyc);
      end
      if (bus.wren_rcf) begin
        if (exp_rcf.size() == 0) check("rcf_unexpected", 1, 0);
        else begin
          check("rcf_data", bus.datain_rcf, exp_rcf.pop_front());
          check("rcf_after_data", rf_writes, exp_rcf_at.pop_front());
        end
      end
      if (bus.fib_mac_rx_stat_rd) check("stat_rd_rcf_space", bus.wrfull_rcf, 0);
      prev_rd = bus.fib_mac_rx_rd;
    end
  endtask

  // Waits until both FMAC FIFOs are drained and the block has sat idle, then settles the scoreboard.
  task automatic wait_quiet(input string name, input int budget);
    int quiet = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_fib);
      if (sq.size() == 0 && dq.size() == 0 && !test && bus.fib_mac_rx_stat_empty &&
          !bus.fib_mac_rx_stat_rd && !bus.wren_rcf)
        quiet++;
      else
        quiet = 0;
      if (quiet >= 6) break;
    end
    check({name, "_finished"}, quiet >= 6, 1);
    check({name, "_rf_left"}, exp_rf.size(), 0);
    check({name, "_rcf_left"}, exp_rcf.size(), 0);
    check({name, "_drop_cnt"}, drop_cnt, exp_drop);
  endtask

  initial begin
    int r0;
    int bc;
    int r;
    reset = 1'b1;
    bus.wrusedw_rf            = '0;
    bus.wrfull_rcf            = 1'b0;
    bus.fib_mac_rx_empty      = 1'b1;
    bus.fib_mac_rx_stat_empty = 1'b1;
    bus.fib_mac_rx_data       = '0;
    bus.fib_mac_rx_stat       = '0;
    fork
      fifo_model();
      monitor();
    join_none
    repeat (3) @(posedge clk_fib);
    #1;
    check("reset_strobes", {bus.fib_mac_rx_rd, bus.fib_mac_rx_stat_rd, bus.wren_rf, bus.wren_rcf, test}, 0);
    check("reset_datain_rf", bus.datain_rf, 0);
    check("reset_datain_rcf", bus.datain_rcf, 0);
    check("reset_drop_cnt", drop_cnt, 0);
    @(negedge clk_fib);
    reset = 1'b0;

    // Good 64B, 61B, errored 64B followed by good 64B.
    send_frame(64, 0);
    wait_quiet("good64", 200);
    send_frame(61, 0);
    wait_quiet("b61", 200);
    r0 = rd_count;
    send_frame(64, 1);
    send_frame(64, 0);
    wait_quiet("err_then_good", 400);
    check("err_reads", rd_count - r0, 16);

    // rf backpressure: 5 free words is not enough for 8, 8 free is.
    bus.wrusedw_rf = 12'd4090;
    r0 = rd_count;
    send_frame(64, 0);
    repeat (30) @(negedge clk_fib);
    check("bp_no_read", rd_count - r0, 0);
    check("bp_rf_pending", exp_rf.size(), 8);
    check("bp_test_low", test, 0);
    bus.wrusedw_rf = 12'd4087;
    wait_quiet("bp_release", 200);
    bus.wrusedw_rf = '0;

    // Data bubble of 3 cycles after the 3rd read: writes stretch from 7 to 10 cycles apart.
    wr_stamps.delete();
    bubble_at = rd_count + 3;
    send_frame(64, 0);
    wait_quiet("bubble", 200);
    bubble_at = 0;
    check("bubble_writes", wr_stamps.size(), 8);
    if (wr_stamps.size() == 8) begin
      check("bubble_span", wr_stamps[7] - wr_stamps[0], 10);
      check("bubble_gap", wr_stamps[3] - wr_stamps[2], 4);
    end

    // Length limits.
    r0 = rd_count;
    send_frame(0, 0);
    wait_quiet("bc0", 100);
    check("bc0_reads", rd_count - r0, 0);
    r0 = rd_count;
    send_frame(9601, 0);
    wait_quiet("bc9601", 3000);
    check("bc9601_reads", rd_count - r0, 1201);
    r0 = rd_count;
    send_frame(9600, 0);
    wait_quiet("bc9600", 3000);
    check("bc9600_reads", rd_count - r0, 1200);

    // rcf full holds the block in IDLE without touching the status FIFO.
    bus.wrfull_rcf = 1'b1;
    send_frame(16, 0);
    repeat (10) @(negedge clk_fib);
    check("rcf_full_hold", sq.size(), 1);
    bus.wrfull_rcf = 1'b0;
    wait_quiet("rcf_release", 200);

    // Random mix with random FIFO empties.
    rand_stall = 1'b1;
    for (int i = 0; i < 25; i++) begin
      r  = $urandom_range(15);
      bc = (r == 0) ? 0 : ((r == 2) ? $urandom_range(9601, 12000) : $urandom_range(1, 200));
      send_frame(bc, r == 1);
    end
    wait_quiet("random", 20000);
    rand_stall = 1'b0;

    // Reset after 4 words of a good frame.
    r0 = rf_writes;
    send_frame(64, 0);
    for (int c = 0; c < 200 && rf_writes < r0 + 4; c++) @(negedge clk_fib);
    check("reset_mid_reached", rf_writes >= r0 + 4, 1);
    #1;
    reset = 1'b1;
    #1;
    check("midreset_strobes", {bus.fib_mac_rx_rd, bus.fib_mac_rx_stat_rd, bus.wren_rf, bus.wren_rcf, test}, 0);
    check("midreset_datain_rf", bus.datain_rf, 0);
    check("midreset_datain_rcf", bus.datain_rcf, 0);
    check("midreset_drop_cnt", drop_cnt, 0);
    dq.delete();
    sq.delete();
    exp_rf.delete();
    exp_rcf.delete();
    exp_rcf_at.delete();
    exp_words_total = 0;
    exp_drop        = 0;
    rf_writes       = 0;
    repeat (3) @(negedge clk_fib);
    reset = 1'b0;
    send_frame(64, 0);
    wait_quiet("after_reset", 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
